ff_bank_cmd_arbiter: RTL

//  Shares one bank of WIDTH set/reset/toggle flip-flops between NREQ requesters.

---
 rtl/ff_bank_cmd_arbiter_pkg.sv | 23 ++
 rtl/ff_bank_cmd_arbiter_if.sv | 30 +++
 rtl/ff_bank_cmd_arbiter_rr_arbiter.sv | 34 +++
 rtl/ff_bank_cmd_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/ff_bank_cmd_arbiter_pkg.sv
// Shared definitions for the arbitrated set/clear/toggle flip-flop bank.
// Holds the op encoding and the per-bit next-state function.
package ff_bank_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_HOLD = 2'b00;
   localparam op_t OP_CLR  = 2'b01;
   localparam op_t OP_SET  = 2'b10;
   localparam op_t OP_TGL  = 2'b11;

   function automatic logic ff_next(input logic q, input op_t op);
      logic n;
      unique case (op)
         OP_CLR:  n = 1'b0;
         OP_SET:  n = 1'b1;
         OP_TGL:  n = ~q;
         default: n = q;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ff_bank_cmd_arbiter_if.sv
// Requester-side bus of the flip-flop bank: per-requester commands in,
// one-hot grant, bank state and apply acknowledge out.
interface ff_bank_cmd_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(NREQ);

   // Handshake: requester i transfers its op/mask on a rising edge where
   // req_valid[i] & req_ready[i]; valid may drop at any time before ready,
   // op/mask matter only on the accepting edge, ready is one-hot or zero.
   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_mask;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      q;
   logic                  ack_valid;
   logic [IDW-1:0]        ack_id;

   modport master (
      output req_valid, req_op, req_mask,
      input  req_ready, q, ack_valid, ack_id
   );

   modport slave (
      input  req_valid, req_op, req_mask,
      output req_ready, q, ack_valid, ack_id
   );

endinterface

// File: rtl/ff_bank_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward,
// wrapping modulo N, and grants the first asserted index.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] gnt_id_o,
   output logic                 any_o
);
   localparam int IDW = $clog2(N);

   logic found;
   int   idx;

   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            gnt_id_o   = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

   assign any_o = found;

endmodule

// File: rtl/ff_bank_cmd_arbiter.sv
// Round-robin shared SR/JK flip-flop bank: accept one command per cycle,
// register it, apply it to the bank on the following edge and pulse an ack.
module ff_bank_cmd_arbiter
   import ff_bank_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   ff_bank_cmd_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_id;
   logic             gnt_any;
   op_t              gnt_op;
   logic [WIDTH-1:0] gnt_mask;

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             cmd_pend_q, cmd_pend_d;
   op_t              cmd_op_q, cmd_op_d;
   logic [WIDTH-1:0] cmd_mask_q, cmd_mask_d;
   logic [IDW-1:0]   cmd_id_q, cmd_id_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ack_valid_q, ack_valid_d;
   logic [IDW-1:0]   ack_id_q, ack_id_d;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req_i    (bus.req_valid),
      .ptr_i    (ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .any_o    (gnt_any)
   );

   // No grant may be observed while the bank is held in reset.
   assign bus.req_ready = rst ? '0 : gnt;

   assign gnt_op   = bus.req_op[2*int'(gnt_id) +: 2];
   assign gnt_mask = bus.req_mask[WIDTH*int'(gnt_id) +: WIDTH];

   always_comb begin
      ptr_d       = ptr_q;
      cmd_pend_d  = gnt_any;
      cmd_op_d    = cmd_op_q;
      cmd_mask_d  = cmd_mask_q;
      cmd_id_d    = cmd_id_q;
      q_d         = q_q;
      ack_valid_d = cmd_pend_q;
      ack_id_d    = ack_id_q;

      if (gnt_any) begin
         ptr_d      = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
         cmd_op_d   = gnt_op;
         cmd_mask_d = gnt_mask;
         cmd_id_d   = gnt_id;
      end

      // Apply stage runs in parallel with the accept stage above.
      if (cmd_pend_q) begin
         ack_id_d = cmd_id_q;
         for (int b = 0; b < WIDTH; b++) begin
            if (cmd_mask_q[b]) q_d[b] = ff_next(q_q[b], cmd_op_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         cmd_pend_q  <= 1'b0;
         cmd_op_q    <= OP_HOLD;
         cmd_mask_q  <= '0;
         cmd_id_q    <= '0;
         q_q         <= '0;
         ack_valid_q <= 1'b0;
         ack_id_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cmd_pend_q  <= cmd_pend_d;
         cmd_op_q    <= cmd_op_d;
         cmd_mask_q  <= cmd_mask_d;
         cmd_id_q    <= cmd_id_d;
         q_q         <= q_d;
         ack_valid_q <= ack_valid_d;
         ack_id_q    <= ack_id_d;
      end
   end

   assign bus.q         = q_q;
   assign bus.ack_valid = ack_valid_q;
   assign bus.ack_id    = ack_id_q;

   a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(bus.req_ready));
   a_ready_needs_valid : assert property (@(posedge clk) disable iff (rst)
      (bus.req_ready & ~bus.req_valid) == '0);

endmodule
